// File: rtl/div32_seq.sv
// div32_seq: multicycle signed integer divider for the execute stage.
// Restoring radix-2 shift-subtract on operand magnitudes, then a sign fix-up.
// A start in IDLE takes 34 edges for a normal divide, or 1 edge when the
// divisor is zero or the divide overflows.
//
// Ports:
//   clock          rising-edge clock
//   resetn         synchronous active-low reset
//   ctrl_DIV       start request, accepted only in IDLE
//   data_operandA  dividend, two's complement
//   data_operandB  divisor, two's complement
//   data_result    quotient truncated toward zero; held until the next completion
//   data_exception divide-by-zero / overflow flag for the last operation
//   data_resultRDY one-cycle completion strobe
//   busy           high while an operation is in RUN or FIX
module div32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Unsigned magnitude; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    if (x[WIDTH-1]) begin
      abs_val = ~x + ONE_W;
    end else begin
      abs_val = x;
    end
  endfunction

  state_t           state_q, state_d;
  // Remainder carries one spare top bit so the trial subtraction uses every bit.
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] absb_q, absb_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;

  // Next-state, datapath iteration and output computation.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    absb_d   = absb_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    // {rem,q} shifted left by one; top bit of trial is the borrow/sign.
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {2'b00, absb_q};

    case (state_q)
      S_IDLE: begin
        if (ctrl_DIV) begin
          sign_a_d = data_operandA[WIDTH-1];
          sign_b_d = data_operandB[WIDTH-1];
          absb_d   = abs_val(data_operandB);
          if (data_operandB == {WIDTH{1'b0}}) begin
            result_d = {WIDTH{1'b0}};
            exc_d    = 1'b1;
            rdy_d    = 1'b1;
            state_d  = S_DONE;
          end else if ((data_operandA == MIN_NEG) && (data_operandB == ALL_ONES)) begin
            result_d = MIN_NEG;
            exc_d    = 1'b1;
            rdy_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            quo_d   = abs_val(data_operandA);
            rem_d   = {(WIDTH+1){1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!trial[WIDTH+1]) begin
          rem_d = trial[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX: begin
        if (sign_a_q ^ sign_b_q) begin
          result_d = ~quo_q + ONE_W;
        end else begin
          result_d = quo_q;
        end
        exc_d   = 1'b0;
        rdy_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      rem_q    <= {(WIDTH+1){1'b0}};
      quo_q    <= {WIDTH{1'b0}};
      absb_q   <= {WIDTH{1'b0}};
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      result_q <= {WIDTH{1'b0}};
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      absb_q   <= absb_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_div32_seq.sv
// Testbench for div32_seq: directed cases plus random operands, with a
// queue-based scoreboard checked by an independent monitor on every RDY strobe.
module tb_div32_seq;

  logic        clock;
  logic        resetn;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  div32_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          rdy_edge;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Rising-edge counter used to measure latency.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: plain signed arithmetic plus the two exception rules.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic x);
    if (b == 32'd0) begin
      r = 32'd0;
      x = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      x = 1'b1;
    end else begin
      r = 32'($signed(a) / $signed(b));
      x = 1'b0;
    end
  endfunction

  // Monitor: every RDY strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (data_resultRDY) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rdy: got RDY with result 0x%08h, expected no RDY", data_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", data_result, e.res);
        chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
        chk("latency_edge", cyc, e.rdy_edge);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || data_resultRDY) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (busy || data_resultRDY) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: got busy=%0b rdy=%0b expected idle within 200 cycles", busy, data_resultRDY);
    end
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!data_resultRDY && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!data_resultRDY) begin
      tests++;
      fails++;
      $display("FAIL wait_rdy: got no RDY expected RDY within 200 cycles");
    end
  endtask

  // Issue one start; the sampling edge is the next rising edge (cyc+1).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit track);
    exp_t e;
    logic [31:0] r;
    logic x;
    wait_idle();
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV = 1'b1;
    if (track) begin
      ref_div(a, b, r, x);
      e.res = r;
      e.exc = x;
      e.rdy_edge = cyc + (x ? 1 : 34);
      exp_q.push_back(e);
    end
    @(negedge clock);
    ctrl_DIV = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [31:0] r, a, b;
    logic x;

    resetn = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    // Positive divide, strobe width and output hold.
    start_op(32'd100, 32'd7, 1'b1);
    chk("busy_in_run", {31'd0, busy}, 32'd1);
    wait_rdy();
    @(negedge clock);
    chk("rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);
    repeat (10) @(negedge clock);
    chk("result_hold", data_result, 32'd14);

    // Reset mid-RUN discards the operation.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (8) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_result", data_result, 32'd0);
    chk("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
    resetn = 1'b1;
    repeat (45) @(negedge clock);

    // Signed truncation, exceptions, recovery.
    start_op(32'hFFFF_FF9C, 32'd7, 1'b1);
    start_op(32'd100, 32'hFFFF_FFF9, 1'b1);
    start_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);
    start_op(32'd6, 32'hFFFF_FFF9, 1'b1);
    start_op(32'h8000_0000, 32'd2, 1'b1);
    start_op(32'd5, 32'd0, 1'b1);
    start_op(32'd9, 32'd3, 1'b1);
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    start_op(32'h8000_0000, 32'd1, 1'b1);
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1);

    // Restart attempts during RUN, FIX and DONE are ignored.
    wait_idle();
    data_operandA = 32'd1000;
    data_operandB = 32'd10;
    ctrl_DIV = 1'b1;
    ref_div(32'd1000, 32'd10, r, x);
    e.res = r;
    e.exc = x;
    e.rdy_edge = cyc + 34;
    exp_q.push_back(e);
    for (int k = 2; k <= 36; k++) begin
      @(negedge clock);
      if (k == 5 || k == 34 || k == 35) begin
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        ctrl_DIV = 1'b1;
      end else begin
        ctrl_DIV = 1'b0;
      end
    end
    start_op(32'd5, 32'd5, 1'b1);

    // Random operands biased toward interesting classes.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom; b = $urandom_range(1, 20); if ($urandom_range(0, 1) == 1) b = -b; end
        2: begin a = $urandom; b = 32'd0; end
        3: begin
          a = 32'h8000_0000;
          case ($urandom_range(0, 3))
            0: b = 32'hFFFF_FFFF;
            1: b = 32'd1;
            2: b = 32'd2;
            default: b = 32'h8000_0000;
          endcase
        end
        4: begin a = $urandom_range(0, 50); b = $urandom; end
        default: begin a = $urandom; b = a; end
      endcase
      start_op(a, b, 1'b1);
    end

    wait_idle();
    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
